// File: rtl/apb4_mem_completer.sv
// APB4 completer backed by a byte-strobed register memory, with runtime wait
// states, decode-error responses and a sticky protocol-violation flag.
module apb4_mem_completer #(
  parameter int                 ADDR_W    = 32,
  parameter int                 DATA_W    = 32,
  parameter int                 DEPTH     = 256,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = '0,
  parameter int                 WAIT_W    = 4
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_W-1:0]     PADDR,
  input  logic [DATA_W-1:0]     PWDATA,
  input  logic [DATA_W/8-1:0]   PSTRB,
  input  logic [WAIT_W-1:0]     wait_cfg,
  output logic                  PREADY,
  output logic [DATA_W-1:0]     PRDATA,
  output logic                  PSLVERR,
  output logic                  prot_err,
  output logic [15:0]           xfer_cnt
);

  localparam int STRB_W  = DATA_W / 8;
  localparam int BYTE_SH = $clog2(STRB_W);
  localparam int IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {ST_IDLE, ST_ACCESS} state_t;

  state_t              state_q;
  logic [WAIT_W-1:0]   wcnt_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                write_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   strb_q;
  logic                prot_err_q;
  logic [15:0]         xfer_cnt_q;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic [ADDR_W-1:0]   off;
  logic [ADDR_W-1:0]   idx_full;
  logic [IDX_W-1:0]    idx;
  logic                dec_err;
  logic                pready;
  logic                commit_wr;

  // Decode works on the address latched in setup, so it is stable across waits.
  always_comb begin
    off      = addr_q - BASE_ADDR;
    idx_full = off >> BYTE_SH;
    idx      = idx_full[IDX_W-1:0];
    dec_err  = (addr_q < BASE_ADDR) ||
               (idx_full >= ADDR_W'(DEPTH)) ||
               (|(off & ADDR_W'(STRB_W - 1)));
  end

  assign pready    = (state_q == ST_ACCESS) && (wcnt_q == '0) && PSEL && PENABLE;
  assign commit_wr = pready && write_q && !dec_err;

  assign PREADY   = pready;
  assign PSLVERR  = pready && dec_err;
  assign PRDATA   = (pready && !write_q && !dec_err) ? mem_q[idx] : '0;
  assign prot_err = prot_err_q;
  assign xfer_cnt = xfer_cnt_q;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q    <= ST_IDLE;
      wcnt_q     <= '0;
      addr_q     <= '0;
      write_q    <= 1'b0;
      wdata_q    <= '0;
      strb_q     <= '0;
      prot_err_q <= 1'b0;
      xfer_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (PSEL && !PENABLE) begin
            state_q <= ST_ACCESS;
            addr_q  <= PADDR;
            write_q <= PWRITE;
            wdata_q <= PWDATA;
            strb_q  <= PSTRB;
            wcnt_q  <= wait_cfg;
          end else if (PSEL && PENABLE) begin
            prot_err_q <= 1'b1;
          end
        end
        ST_ACCESS: begin
          if (PSEL && PENABLE) begin
            if (wcnt_q != '0) begin
              wcnt_q <= wcnt_q - WAIT_W'(1);
            end else begin
              xfer_cnt_q <= xfer_cnt_q + 16'd1;
              state_q    <= ST_IDLE;
            end
          end else begin
            // Requester left the access phase early: abort without writing.
            prot_err_q <= 1'b1;
            state_q    <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (commit_wr) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (strb_q[b]) mem_q[idx][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_apb4_mem_completer.sv
// Directed bench for apb4_mem_completer: one task per scenario, hand-computed
// expectations, inline comparisons and a single summary line.
module tb_apb4_mem_completer;

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic        PSEL = 1'b0;
  logic        PENABLE = 1'b0;
  logic        PWRITE = 1'b0;
  logic [31:0] PADDR = '0;
  logic [31:0] PWDATA = '0;
  logic [3:0]  PSTRB = '0;
  logic [3:0]  wait_cfg = '0;
  logic        PREADY;
  logic [31:0] PRDATA;
  logic        PSLVERR;
  logic        prot_err;
  logic [15:0] xfer_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] rd;
  logic        er;
  int          cy;

  apb4_mem_completer dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB),
    .wait_cfg(wait_cfg), .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR),
    .prot_err(prot_err), .xfer_cnt(xfer_cnt)
  );

  always #5 PCLK = ~PCLK;

  task automatic do_reset();
    PSEL = 1'b0; PENABLE = 1'b0; PRESETn = 1'b0;
    repeat (2) @(posedge PCLK);
    #1 PRESETn = 1'b1;
  endtask

  // One full transfer. Inputs change 1 after the edge, outputs are sampled 2 after.
  // wait_cfg is forced to 0 once setup is over, which must not shorten the transfer.
  task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, input logic [3:0] waits, input bit b2b,
                          output logic [31:0] rdata, output logic err, output int cycles);
    bit got = 0;
    rdata = '0; err = 1'b0;
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr;
    PWDATA = wdata; PSTRB = strb; wait_cfg = waits;
    @(posedge PCLK); #1;
    PENABLE = 1'b1; wait_cfg = 4'd0;
    cycles = 2; #1;
    for (int k = 0; k < 40 && !got; k++) begin
      if (PREADY) begin
        got = 1; rdata = PRDATA; err = PSLVERR;
      end else begin
        @(posedge PCLK); #2; cycles++;
      end
    end
    if (!got) begin
      n_cmp++; n_fail++;
      $display("FAIL xfer_timeout: no PREADY for addr %h, required within 40 cycles", addr);
    end
    if (!b2b) begin
      @(posedge PCLK); #1;
      PSEL = 1'b0; PENABLE = 1'b0;
    end
  endtask

  task automatic test_reset();
    do_reset(); #1;
    n_cmp++; if (PREADY !== 1'b0)    begin n_fail++; $display("FAIL rst_pready: got %b need 0", PREADY); end
    n_cmp++; if (PRDATA !== 32'h0)   begin n_fail++; $display("FAIL rst_prdata: got %h need 0", PRDATA); end
    n_cmp++; if (PSLVERR !== 1'b0)   begin n_fail++; $display("FAIL rst_pslverr: got %b need 0", PSLVERR); end
    n_cmp++; if (prot_err !== 1'b0)  begin n_fail++; $display("FAIL rst_prot_err: got %b need 0", prot_err); end
    n_cmp++; if (xfer_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_xfer_cnt: got %0d need 0", xfer_cnt); end
    apb_xfer(1'b0, 32'h10, 32'h0, 4'h0, 4'd0, 1'b0, rd, er, cy);
    n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL rst_read: got %h need 0", rd); end
  endtask

  task automatic test_basic();
    do_reset();
    apb_xfer(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 4'd0, 1'b0, rd, er, cy);
    n_cmp++; if (cy !== 2)   begin n_fail++; $display("FAIL basic_wr_cycles: got %0d need 2", cy); end
    n_cmp++; if (er !== 1'b0) begin n_fail++; $display("FAIL basic_wr_err: got %b need 0", er); end
    apb_xfer(1'b0, 32'h10, 32'h0, 4'h0, 4'd0, 1'b0, rd, er, cy);
    n_cmp++; if (cy !== 2)   begin n_fail++; $display("FAIL basic_rd_cycles: got %0d need 2", cy); end
    n_cmp++; if (rd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL basic_rd_data: got %h need deadbeef", rd); end
    n_cmp++; if (xfer_cnt !== 16'd2) begin n_fail++; $display("FAIL basic_xfer_cnt: got %0d need 2", xfer_cnt); end
  endtask

  task automatic test_waits();
    apb_xfer(1'b1, 32'h20, 32'h0BAD_F00D, 4'hF, 4'd3, 1'b0, rd, er, cy);
    n_cmp++; if (cy !== 5) begin n_fail++; $display("FAIL wait_wr_cycles: got %0d need 5", cy); end
    apb_xfer(1'b0, 32'h20, 32'h0, 4'h0, 4'd3, 1'b0, rd, er, cy);
    n_cmp++; if (cy !== 5) begin n_fail++; $display("FAIL wait_rd_cycles: got %0d need 5", cy); end
    n_cmp++; if (rd !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL wait_rd_data: got %h need 0badf00d", rd); end
    n_cmp++; if (xfer_cnt !== 16'd4) begin n_fail++; $display("FAIL wait_xfer_cnt: got %0d need 4", xfer_cnt); end
  endtask

  task automatic test_strobe();
    apb_xfer(1'b1, 32'h30, 32'h1122_3344, 4'hF, 4'd0, 1'b0, rd, er, cy);
    apb_xfer(1'b1, 32'h30, 32'hAABB_CCDD, 4'b0101, 4'd1, 1'b0, rd, er, cy);
    apb_xfer(1'b0, 32'h30, 32'h0, 4'h0, 4'd0, 1'b0, rd, er, cy);
    n_cmp++; if (rd !== 32'h11BB_33DD) begin n_fail++; $display("FAIL strb_merge: got %h need 11bb33dd", rd); end
    apb_xfer(1'b1, 32'h30, 32'hFFFF_FFFF, 4'h0, 4'd0, 1'b0, rd, er, cy);
    n_cmp++; if (er !== 1'b0) begin n_fail++; $display("FAIL strb_zero_err: got %b need 0", er); end
    apb_xfer(1'b0, 32'h30, 32'h0, 4'h0, 4'd0, 1'b0, rd, er, cy);
    n_cmp++; if (rd !== 32'h11BB_33DD) begin n_fail++; $display("FAIL strb_zero_data: got %h need 11bb33dd", rd); end
  endtask

  task automatic test_errors();
    do_reset();
    apb_xfer(1'b0, 32'h400, 32'h0, 4'h0, 4'd0, 1'b0, rd, er, cy);
    n_cmp++; if (er !== 1'b1)  begin n_fail++; $display("FAIL err_range_rd: got %b need 1", er); end
    n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL err_range_data: got %h need 0", rd); end
    apb_xfer(1'b0, 32'h02, 32'h0, 4'h0, 4'd0, 1'b0, rd, er, cy);
    n_cmp++; if (er !== 1'b1)  begin n_fail++; $display("FAIL err_misalign_rd: got %b need 1", er); end
    apb_xfer(1'b1, 32'h404, 32'hFFFF_FFFF, 4'hF, 4'd2, 1'b0, rd, er, cy);
    n_cmp++; if (er !== 1'b1)  begin n_fail++; $display("FAIL err_range_wr: got %b need 1", er); end
    n_cmp++; if (cy !== 4)     begin n_fail++; $display("FAIL err_range_cycles: got %0d need 4", cy); end
    apb_xfer(1'b1, 32'h3FC, 32'hCAFE_F00D, 4'hF, 4'd0, 1'b0, rd, er, cy);
    n_cmp++; if (er !== 1'b0)  begin n_fail++; $display("FAIL last_word_wr_err: got %b need 0", er); end
    apb_xfer(1'b0, 32'h3FC, 32'h0, 4'h0, 4'd0, 1'b0, rd, er, cy);
    n_cmp++; if (rd !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL last_word_rd: got %h need cafef00d", rd); end
    apb_xfer(1'b0, 32'h04, 32'h0, 4'h0, 4'd0, 1'b0, rd, er, cy);
    n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL err_alias_unchanged: got %h need 0", rd); end
    apb_xfer(1'b1, 32'h12, 32'h5555_5555, 4'hF, 4'd0, 1'b0, rd, er, cy);
    n_cmp++; if (er !== 1'b1)  begin n_fail++; $display("FAIL err_misalign_wr: got %b need 1", er); end
    apb_xfer(1'b0, 32'h10, 32'h0, 4'h0, 4'd0, 1'b0, rd, er, cy);
    n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL err_misalign_unchanged: got %h need 0", rd); end
    n_cmp++; if (xfer_cnt !== 16'd8) begin n_fail++; $display("FAIL err_xfer_cnt: got %0d need 8", xfer_cnt); end
  endtask

  task automatic test_back_to_back();
    apb_xfer(1'b1, 32'h40, 32'h0102_0304, 4'hF, 4'd0, 1'b1, rd, er, cy);
    apb_xfer(1'b0, 32'h40, 32'h0, 4'h0, 4'd0, 1'b1, rd, er, cy);
    n_cmp++; if (cy !== 2) begin n_fail++; $display("FAIL b2b_cycles: got %0d need 2", cy); end
    n_cmp++; if (rd !== 32'h0102_0304) begin n_fail++; $display("FAIL b2b_data: got %h need 01020304", rd); end
    apb_xfer(1'b0, 32'h3FC, 32'h0, 4'h0, 4'd1, 1'b0, rd, er, cy);
    n_cmp++; if (rd !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL b2b_third: got %h need cafef00d", rd); end
    n_cmp++; if (prot_err !== 1'b0) begin n_fail++; $display("FAIL b2b_no_prot_err: got %b need 0", prot_err); end
    n_cmp++; if (xfer_cnt !== 16'd11) begin n_fail++; $display("FAIL b2b_xfer_cnt: got %0d need 11", xfer_cnt); end
  endtask

  task automatic test_violations();
    do_reset();
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = 32'h50; PWDATA = 32'h1234_5678; PSTRB = 4'hF;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; #1;
    n_cmp++; if (prot_err !== 1'b1)  begin n_fail++; $display("FAIL viol_nosetup_flag: got %b need 1", prot_err); end
    n_cmp++; if (xfer_cnt !== 16'd0) begin n_fail++; $display("FAIL viol_nosetup_cnt: got %0d need 0", xfer_cnt); end

    do_reset();
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h50; PWDATA = 32'hDEAD_BEEF; PSTRB = 4'hF; wait_cfg = 4'd5;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    repeat (2) @(posedge PCLK);
    #1;
    n_cmp++; if (PREADY !== 1'b0) begin n_fail++; $display("FAIL viol_wait_pready: got %b need 0", PREADY); end
    PSEL = 1'b0; PENABLE = 1'b0;
    @(posedge PCLK); #2;
    n_cmp++; if (prot_err !== 1'b1)  begin n_fail++; $display("FAIL viol_drop_flag: got %b need 1", prot_err); end
    n_cmp++; if (xfer_cnt !== 16'd0) begin n_fail++; $display("FAIL viol_drop_cnt: got %0d need 0", xfer_cnt); end
    apb_xfer(1'b0, 32'h50, 32'h0, 4'h0, 4'd0, 1'b0, rd, er, cy);
    n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL viol_drop_nowrite: got %h need 0", rd); end
    n_cmp++; if (prot_err !== 1'b1) begin n_fail++; $display("FAIL viol_sticky: got %b need 1", prot_err); end

    do_reset();
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h60; PWDATA = 32'h7777_7777; PSTRB = 4'hF; wait_cfg = 4'd5;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #3;
    PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; #1;
    n_cmp++; if (PREADY !== 1'b0)    begin n_fail++; $display("FAIL midrst_pready: got %b need 0", PREADY); end
    n_cmp++; if (prot_err !== 1'b0)  begin n_fail++; $display("FAIL midrst_prot_err: got %b need 0", prot_err); end
    @(posedge PCLK); #1 PRESETn = 1'b1;
    apb_xfer(1'b0, 32'h60, 32'h0, 4'h0, 4'd0, 1'b0, rd, er, cy);
    n_cmp++; if (rd !== 32'h0)       begin n_fail++; $display("FAIL midrst_nowrite: got %h need 0", rd); end
    n_cmp++; if (xfer_cnt !== 16'd1) begin n_fail++; $display("FAIL midrst_cnt: got %0d need 1", xfer_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_waits();
    test_strobe();
    test_errors();
    test_back_to_back();
    test_violations();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
